// File: rtl/snax_shadow_csr.sv
// rtl/snax_shadow_csr.sv - double-buffered CSR manager with launch/done accelerator handshake
// Shadow registers are copied to the active set on launch; one launch may queue behind a busy accelerator.
module snax_shadow_csr #(
  parameter int NumRwCsr     = 4,
  parameter int NumRoCsr     = 2,
  parameter int CsrDataWidth = 32,
  parameter int CsrAddrWidth = $clog2(NumRwCsr + NumRoCsr + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [CsrAddrWidth-1:0]          csr_addr_i,
  input  logic [CsrDataWidth-1:0]          csr_wr_data_i,
  input  logic                             csr_wr_en_i,
  input  logic                             csr_req_valid_i,
  output logic                             csr_req_ready_o,
  output logic [CsrDataWidth-1:0]          csr_rd_data_o,
  output logic                             csr_rsp_valid_o,
  input  logic                             csr_rsp_ready_i,
  output logic [NumRwCsr*CsrDataWidth-1:0] csr_cfg_o,
  input  logic [NumRoCsr*CsrDataWidth-1:0] csr_status_i,
  output logic                             acc_start_o,
  input  logic                             acc_done_i,
  output logic                             acc_busy_o
);

  localparam int CtrlAddr = NumRwCsr + NumRoCsr;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    PENDING = 2'd2
  } state_e;

  state_e                          state_q, state_d;
  logic [CsrDataWidth-1:0]         shadow_q [NumRwCsr];
  logic [CsrDataWidth-1:0]         shadow_d [NumRwCsr];
  logic [NumRwCsr*CsrDataWidth-1:0] cfg_q, cfg_d;
  logic [CsrDataWidth-1:0]         rd_data_q, rd_data_d, rd_mux;
  logic                            rsp_valid_q, rsp_valid_d;
  logic                            start_q, start_d;
  logic                            addr_rw, addr_ctrl;
  logic                            req_ready, accept, wr_rw, launch, copy;

  always_comb begin
    addr_rw   = int'(csr_addr_i) < NumRwCsr;
    addr_ctrl = int'(csr_addr_i) == CtrlAddr;
    // A queued launch blocks anything that could change the shadow set or launch again
    req_ready = !(rsp_valid_q && !csr_rsp_ready_i) &&
                !((state_q == PENDING) && csr_wr_en_i && (addr_rw || addr_ctrl));
    accept    = csr_req_valid_i && req_ready;
    wr_rw     = accept && csr_wr_en_i && addr_rw;
    launch    = accept && csr_wr_en_i && addr_ctrl && csr_wr_data_i[0];
  end

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NumRwCsr; k++) begin
      if (int'(csr_addr_i) == k) rd_mux = shadow_q[k];
    end
    for (int j = 0; j < NumRoCsr; j++) begin
      if (int'(csr_addr_i) == NumRwCsr + j) rd_mux = csr_status_i[j*CsrDataWidth +: CsrDataWidth];
    end
    if (addr_ctrl) begin
      rd_mux = {{(CsrDataWidth-2){1'b0}}, state_q == PENDING, state_q != IDLE};
    end
  end

  always_comb begin
    for (int k = 0; k < NumRwCsr; k++) begin
      shadow_d[k] = shadow_q[k];
      if (wr_rw && int'(csr_addr_i) == k) shadow_d[k] = csr_wr_data_i;
    end
  end

  always_comb begin
    state_d = state_q;
    copy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch) begin
          copy    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (acc_done_i && launch) begin
          copy = 1'b1;
        end else if (acc_done_i) begin
          state_d = IDLE;
        end else if (launch) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (acc_done_i) begin
          copy    = 1'b1;
          state_d = BUSY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Copy from shadow_d so a write landing in the copy cycle is included
  always_comb begin
    cfg_d   = cfg_q;
    start_d = copy;
    if (copy) begin
      for (int k = 0; k < NumRwCsr; k++) begin
        cfg_d[k*CsrDataWidth +: CsrDataWidth] = shadow_d[k];
      end
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rd_data_d   = rd_data_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rd_data_d   = rd_mux;
    end else if (csr_rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      rd_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      start_q     <= 1'b0;
      for (int k = 0; k < NumRwCsr; k++) shadow_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      rd_data_q   <= rd_data_d;
      rsp_valid_q <= rsp_valid_d;
      start_q     <= start_d;
      for (int k = 0; k < NumRwCsr; k++) shadow_q[k] <= shadow_d[k];
    end
  end

  assign csr_req_ready_o = req_ready;
  assign csr_rd_data_o   = rd_data_q;
  assign csr_rsp_valid_o = rsp_valid_q;
  assign csr_cfg_o       = cfg_q;
  assign acc_start_o     = start_q;
  assign acc_busy_o      = state_q != IDLE;

endmodule

// File: tb/tb_snax_shadow_csr.sv
// tb/tb_snax_shadow_csr.sv - scoreboard bench for snax_shadow_csr
// Inputs change 1 time unit after posedge; outputs are sampled then or at negedge.
module tb_snax_shadow_csr;
  localparam int NRW = 4;
  localparam int NRO = 2;
  localparam int DW  = 32;
  localparam int AW  = 3;
  localparam logic [AW-1:0] LA = 3'd6;

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     req_addr;
  logic [DW-1:0]     wr_data;
  logic              wr_en;
  logic              req_valid;
  logic              req_ready;
  logic [DW-1:0]     rd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [NRW*DW-1:0] cfg;
  logic [NRO*DW-1:0] status;
  logic              start;
  logic              done;
  logic              busy;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] cur_exp;
  logic          accepted;
  logic [DW-1:0] sh_m [NRW];

  snax_shadow_csr dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .csr_addr_i     (req_addr),
    .csr_wr_data_i  (wr_data),
    .csr_wr_en_i    (wr_en),
    .csr_req_valid_i(req_valid),
    .csr_req_ready_o(req_ready),
    .csr_rd_data_o  (rd_data),
    .csr_rsp_valid_o(rsp_valid),
    .csr_rsp_ready_i(rsp_ready),
    .csr_cfg_o      (cfg),
    .csr_status_i   (status),
    .acc_start_o    (start),
    .acc_done_i     (done),
    .acc_busy_o     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] cfg_word(input int k);
    return cfg[k*DW +: DW];
  endfunction

  // Advance one clock: pop responses handshaken this cycle, push expectations for accepts
  task automatic cycle();
    logic [DW-1:0] e;
    @(negedge clk);
    accepted = 1'b0;
    if (!rst && rsp_valid && rsp_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected got=%h", rd_data);
      end else begin
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          bad++;
          $display("FAIL rsp_data got=%h exp=%h", rd_data, e);
        end
      end
    end
    if (!rst && req_valid && req_ready) begin
      exp_q.push_back(cur_exp);
      accepted = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                      input logic [DW-1:0] e);
    req_addr  = a;
    wr_en     = w;
    wr_data   = d;
    cur_exp   = e;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (accepted) break;
    end
    if (!accepted) begin
      total++;
      bad++;
      $display("FAIL send_timeout addr=%0d", a);
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) cycle();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_left got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    total++;
    if ({cfg, start, busy, rsp_valid, rd_data, req_ready} !== {{(NRW*DW){1'b0}}, 3'b000, {DW{1'b0}}, 1'b1}) begin
      bad++;
      $display("FAIL reset_state cfg=%h start=%b busy=%b rsp_valid=%b rd=%h ready=%b exp all 0 ready=1",
               cfg, start, busy, rsp_valid, rd_data, req_ready);
    end
  endtask

  task automatic test_read_map();
    for (int a = 0; a < 8; a++) begin
      send(AW'(a), 1'b0, '0, '0);
      total++;
      if (rsp_valid !== 1'b1) begin
        bad++;
        $display("FAIL read_latency addr=%0d rsp_valid=%b exp=1", a, rsp_valid);
      end
    end
    drain();
  endtask

  task automatic test_launch();
    send(3'd1, 1'b1, 32'hA5A5_0001, sh_m[1]);
    sh_m[1] = 32'hA5A5_0001;
    total++;
    if (cfg_word(1) !== 32'h0) begin
      bad++;
      $display("FAIL shadow_isolated got=%h exp=0", cfg_word(1));
    end
    send(LA, 1'b1, 32'h1, 32'h0);
    total++;
    if ({cfg_word(1), start, busy} !== {32'hA5A5_0001, 2'b11}) begin
      bad++;
      $display("FAIL launch_copy cfg1=%h start=%b busy=%b exp a5a50001 1 1", cfg_word(1), start, busy);
    end
    cycle();
    total++;
    if (start !== 1'b0) begin
      bad++;
      $display("FAIL start_one_cycle got=%b exp=0", start);
    end
    send(LA, 1'b0, '0, 32'h1);
    send(3'd1, 1'b0, '0, 32'hA5A5_0001);
    done = 1'b1;
    cycle();
    done = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL done_idle busy=%b exp=0", busy);
    end
    send(LA, 1'b0, '0, 32'h0);
    drain();
  endtask

  task automatic test_stall();
    rsp_ready = 1'b0;
    send(3'd1, 1'b0, '0, 32'hA5A5_0001);
    req_addr  = 3'd0;
    wr_en     = 1'b0;
    cur_exp   = sh_m[0];
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({req_ready, rsp_valid, rd_data} !== {2'b01, 32'hA5A5_0001}) begin
        bad++;
        $display("FAIL stall_hold ready=%b rsp_valid=%b rd=%h exp 0 1 a5a50001", req_ready, rsp_valid, rd_data);
      end
      cycle();
    end
    rsp_ready = 1'b1;
    send(3'd0, 1'b0, '0, sh_m[0]);
    send(3'd2, 1'b0, '0, sh_m[2]);
    drain();
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_dup rsp_valid=%b exp=0", rsp_valid);
    end
  endtask

  task automatic test_pending();
    send(LA, 1'b1, 32'h1, 32'h0);
    send(3'd0, 1'b1, 32'h7, sh_m[0]);
    sh_m[0] = 32'h7;
    send(LA, 1'b1, 32'h1, 32'h1);
    send(LA, 1'b0, '0, 32'h3);
    drain();
    req_addr  = 3'd2;
    wr_en     = 1'b1;
    wr_data   = 32'h22;
    cur_exp   = sh_m[2];
    req_valid = 1'b1;
    cycle();
    cycle();
    total++;
    if ({req_ready, cfg_word(0)} !== {1'b0, 32'h0}) begin
      bad++;
      $display("FAIL pending_stall ready=%b cfg0=%h exp 0 0", req_ready, cfg_word(0));
    end
    done = 1'b1;
    cycle();
    done = 1'b0;
    total++;
    if ({cfg_word(0), start, busy} !== {32'h7, 2'b11}) begin
      bad++;
      $display("FAIL pending_launch cfg0=%h start=%b busy=%b exp 7 1 1", cfg_word(0), start, busy);
    end
    send(3'd2, 1'b1, 32'h22, sh_m[2]);
    sh_m[2] = 32'h22;
    total++;
    if ({start, cfg_word(2)} !== {1'b0, 32'h0}) begin
      bad++;
      $display("FAIL after_stall start=%b cfg2=%h exp 0 0", start, cfg_word(2));
    end
    drain();
  endtask

  task automatic test_done_launch();
    send(3'd3, 1'b1, 32'h33, sh_m[3]);
    sh_m[3] = 32'h33;
    done = 1'b1;
    send(LA, 1'b1, 32'h1, 32'h1);
    done = 1'b0;
    total++;
    if ({busy, start, cfg_word(3), cfg_word(2)} !== {2'b11, 32'h33, 32'h22}) begin
      bad++;
      $display("FAIL done_and_launch busy=%b start=%b cfg3=%h cfg2=%h exp 1 1 33 22",
               busy, start, cfg_word(3), cfg_word(2));
    end
    cycle();
    total++;
    if ({start, busy} !== 2'b01) begin
      bad++;
      $display("FAIL single_start start=%b busy=%b exp 0 1", start, busy);
    end
    send(LA, 1'b0, '0, 32'h1);
    done = 1'b1;
    cycle();
    done = 1'b0;
    send(LA, 1'b0, '0, 32'h0);
    drain();
  endtask

  task automatic test_ro_and_reset();
    status = {32'hBEEF_0002, 32'hCAFE_0001};
    send(3'd4, 1'b1, 32'h1234, 32'hCAFE_0001);
    send(3'd4, 1'b0, '0, 32'hCAFE_0001);
    send(3'd5, 1'b0, '0, 32'hBEEF_0002);
    send(3'd7, 1'b1, 32'hFFFF, 32'h0);
    send(3'd7, 1'b0, '0, 32'h0);
    send(LA, 1'b1, 32'h1, 32'h0);
    send(LA, 1'b1, 32'h1, 32'h1);
    send(LA, 1'b0, '0, 32'h3);
    drain();
    send(3'd0, 1'b0, '0, sh_m[0]);
    rst  = 1'b1;
    done = 1'b1;
    cycle();
    rst  = 1'b0;
    done = 1'b0;
    exp_q.delete();
    for (int k = 0; k < NRW; k++) sh_m[k] = '0;
    total++;
    if ({cfg, start, busy, rsp_valid, rd_data} !== {{(NRW*DW){1'b0}}, 3'b000, {DW{1'b0}}}) begin
      bad++;
      $display("FAIL reset_mid_pending cfg=%h start=%b busy=%b rsp_valid=%b rd=%h exp all 0",
               cfg, start, busy, rsp_valid, rd_data);
    end
    send(LA, 1'b0, '0, 32'h0);
    send(3'd0, 1'b0, '0, 32'h0);
    send(3'd1, 1'b0, '0, 32'h0);
    drain();
  endtask

  initial begin
    rst       = 1'b1;
    req_addr  = '0;
    wr_data   = '0;
    wr_en     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    status    = '0;
    done      = 1'b0;
    cur_exp   = '0;
    accepted  = 1'b0;
    for (int k = 0; k < NRW; k++) sh_m[k] = '0;
    test_reset();
    test_read_map();
    test_launch();
    test_stall();
    test_pending();
    test_done_launch();
    test_ro_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snax_shadow_csr.md
# snax_shadow_csr

Parametrised CSR manager for SNAX accelerators with double-buffered configuration, read-only status registers and a launch/done handshake with the datapath. Software writes shadow registers through the CSR request/response channel and then writes the launch register. The block copies the shadow set into the active set that drives the accelerator, pulses a start strobe, and tracks busy state. One launch may be queued while the accelerator is busy.

## Interface
- NumRwCsr, 4: number of read/write configuration registers (≥1).
- NumRoCsr, 2: number of read-only status registers (≥0).
- CsrDataWidth, 32: register width (≥2).
- CsrAddrWidth, $clog2(NumRwCsr+NumRoCsr+1): CSR address width.

Ports (reset is synchronous and active-high; `clk_i` is the only clock):
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- csr_addr_i  in  CsrAddrWidth  request address.
- csr_wr_data_i  in  CsrDataWidth  write data.
- csr_wr_en_i  in  1  1 = write, 0 = read.
- csr_req_valid_i  in  1  request valid.
- csr_req_ready_o  out  1  request ready.
- csr_rd_data_o  out  CsrDataWidth  response data.
- csr_rsp_valid_o  out  1  response valid.
- csr_rsp_ready_i  in  1  response ready.
- csr_cfg_o  out  NumRwCsr*CsrDataWidth  active config; register k is at bits [k*CsrDataWidth +: CsrDataWidth].
- csr_status_i  in  NumRoCsr*CsrDataWidth  status words from the accelerator, same packing.
- acc_start_o  out  1  one-cycle launch strobe.
- acc_done_i  in  1  one-cycle completion pulse.
- acc_busy_o  out  1  high whenever the state is not IDLE.

## Operation
- Address map:
  - 0..NumRwCsr-1: RW shadow registers.
  - NumRwCsr..NumRwCsr+NumRoCsr-1: RO status registers, returning `csr_status_i` sampled on the accept cycle.
  - L = NumRwCsr+NumRoCsr: control register.
  - Any address above L is unmapped.
- Accepting a request: a request is accepted when `csr_req_valid_i && csr_req_ready_o`. Every accepted request produces exactly one response.
  - Read data is the pre-write value of the addressed register.
  - Writes to RO or unmapped addresses are dropped.
  - Unmapped reads return 0.
- Control register:
  - Read value: bit0 = busy, bit1 = pending, other bits 0.
  - A write with bit0 = 1 is a launch. A write with bit0 = 0 has no effect.
- Active set: `csr_cfg_o` is written only by a copy from the shadow set. Shadow writes never alter `csr_cfg_o` directly.
- State machine:
  - IDLE:
    - Launch accepted: copy shadow to active, go to BUSY.
    - `acc_done_i` is ignored.
  - BUSY:
    - `acc_done_i` without launch: go to IDLE.
    - Launch without done: go to PENDING.
    - Done and launch in the same cycle: copy, restart, stay in BUSY.
  - PENDING:
    - `acc_done_i`: copy shadow to active, go to BUSY.
    - `acc_done_i` in the same cycle as an accepted write: the write lands first and is included in the copy.
- Every copy-and-launch raises `acc_start_o` in the following cycle. `acc_done_i` is honoured in any non-IDLE cycle, including the `acc_start_o` cycle.
- `csr_req_ready_o` is combinational and may depend on the request fields:
  - low when `csr_rsp_valid_o && !csr_rsp_ready_i`;
  - additionally low in PENDING for writes to RW addresses or L;
  - high otherwise.
- Reads and RO/unmapped writes are never stalled by PENDING.

## Timing
- Reset (synchronous, `rst_i` = 1 at a clock edge) sets:
  - state IDLE;
  - all shadow registers and `csr_cfg_o` to 0;
  - `csr_rd_data_o` 0, `csr_rsp_valid_o` 0;
  - `acc_start_o` 0, `acc_busy_o` 0.
- Reset mid-operation discards any in-flight response, pending launch and busy state. `acc_done_i` in the reset cycle is ignored.
- Read latency is 1 cycle: accept at edge N gives `csr_rsp_valid_o` = 1 with data after edge N.
- Response behaviour:
  - The response holds until `csr_rsp_ready_i` = 1.
  - A new accept in the same cycle as a response handshake replaces the response back-to-back, with no bubble.
  - Full throughput is 1 request per cycle while `csr_rsp_ready_i` stays high.
- Launch accepted in IDLE at edge N: after edge N, `csr_cfg_o` holds the new values and `acc_start_o` = 1 and `acc_busy_o` = 1. `acc_start_o` returns to 0 after edge N+1.
- Pending launch: `acc_done_i` sampled at edge M gives new `csr_cfg_o` and `acc_start_o` after edge M. `acc_busy_o` stays 1 throughout.
- `acc_start_o` is never high in two consecutive cycles unless `acc_done_i` coincided with the first.

## Test plan
- Reset then read addresses 0..L+1 → all data 0; address L returns 0; each response arrives 1 cycle after accept.
- Write 0xA5A5_0001 to reg 1 → `csr_cfg_o` unchanged; launch → next cycle `csr_cfg_o` reg 1 = 0xA5A5_0001, one-cycle `acc_start_o`, L reads 0x1.
- Hold `csr_rsp_ready_i` = 0 for 3 cycles with valid requests → `csr_req_ready_o` = 0, response data stable; release → drain with no loss or duplication.
- While BUSY: write reg 0 = 7, launch, then attempt a write to reg 2 → write stalled, L reads 0x3; pulse `acc_done_i` → reg 0 active = 7, `acc_start_o` pulses, stalled write is then accepted.
- `acc_done_i` and launch in the same cycle while BUSY → stays BUSY, a single `acc_start_o`, active set copied.
- Write to RO address, read back → value equals `csr_status_i`; assert `rst_i` mid-PENDING → all outputs at their reset values the next cycle.
